rgb_cmp_arbiter: RTL and testbench
==================================

RGB_CMP_ARBITER -- requirements
Module: rgb_cmp_arbiter

Interface
REQ-001 Parameter: HOLD, 8, number of cycles a granted comparison result is shown on the RGB outputs (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  2  request lines; req[i]=1 means requester i has a valid operand pair.
REQ-005 a0, b0  input  2 each  operand pair of requester 0.
REQ-006 a1, b1  input  2 each  operand pair of requester 1.
REQ-007 gnt  output  2  one-hot grant pulse; gnt[i]=1 for exactly one cycle when requester i is accepted.
REQ-008 R, G, B  output  1 each  registered comparison result of the served pair.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 owner  output  1  index of the requester currently or most recently served.

Function
REQ-011 The block SHALL be a three-state FSM: IDLE, SHOW, BLANK.
REQ-012 In IDLE, on a rising edge with req!=0, the FSM SHALL go to SHOW, latch the selected requester's a/b, and assert gnt[sel] for that first SHOW cycle only.
REQ-013 Arbitration SHALL be round-robin: if exactly one req bit is set, that requester wins; if both are set, the requester not equal to owner wins.
REQ-014 Comparison on latched operands (a,b unsigned 2-bit): R=(a<=b), G=(a!=b), B=(a>=b); R,G,B SHALL be valid in the first SHOW cycle (same cycle as gnt).
REQ-015 SHOW SHALL last exactly HOLD cycles, timed by a down-counter loaded with HOLD-1 on entry; the counter reaching 0 moves the FSM to BLANK.
REQ-016 Latched operands and R,G,B SHALL stay constant throughout SHOW, regardless of req/a/b changes.
REQ-017 BLANK SHALL last exactly one cycle with R=G=B=0, then return to IDLE.
REQ-018 Requests arriving during SHOW or BLANK SHALL NOT be granted until the next IDLE evaluation; req bits not held until then are lost (no queuing).
REQ-019 Minimum spacing between two grants SHALL be HOLD+2 cycles (SHOW + BLANK + one IDLE cycle).
REQ-020 In IDLE, R=G=B=0, gnt=0, busy=0.
REQ-021 HOLD=1 SHALL give a single SHOW cycle with gnt and result coincident, then BLANK.
REQ-022 owner SHALL update only on grant and hold its value otherwise.

Reset
REQ-023 While rst_n=0: state=IDLE, gnt=0, R=G=B=0, busy=0, counter=0, latched operands=0, owner=1 (requester 0 wins first contention).
REQ-024 Asserting rst_n mid-SHOW or mid-BLANK SHALL clear all outputs immediately, without waiting for clk; no grant is issued on the first edge after deassertion unless req!=0 on that edge.

Verification
REQ-025 Single request: HOLD=4, req=01, a0=1, b0=2 -> gnt=01 for 1 cycle; RGB=110 for 4 cycles; RGB=000 for 1 cycle; busy low after that.
REQ-026 Contention after reset: req=11, a0=3/b0=0, a1=2/b1=2 -> requester 0 served first (RGB=011); with req=11 held, requester 1 is served next (RGB=101), grants HOLD+2 cycles apart.
REQ-027 Operand change during SHOW: a0 switches from 0 to 3 mid-SHOW -> RGB stays at value for a=0 (R=1) until BLANK.
REQ-028 HOLD=1 boundary: req=10 held continuously -> gnt=10 every 3 cycles; RGB non-zero exactly 1 cycle in 3.
REQ-029 Async reset mid-SHOW: drive rst_n low between clock edges -> R,G,B,busy=0 at once; after release with req=11, requester 0 is granted first.
REQ-030 Exhaustive compare: for all 16 (a,b) pairs on requester 0, sampled RGB equals {a<=b, a!=b, a>=b}.

Source files
------------

// File: rtl/rgb_cmp_arbiter.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : rgb_cmp_arbiter
//  Brief    : Two-requester round-robin arbiter that latches the winning
//             operand pair, shows its 2-bit magnitude comparison on R/G/B for
//             HOLD cycles, blanks for one cycle, then returns to idle.
//  Revision : 1.0  initial release
// ============================================================================
module rgb_cmp_arbiter #(
    parameter int unsigned HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] a0,
    input  logic [1:0] b0,
    input  logic [1:0] a1,
    input  logic [1:0] b1,
    output logic [1:0] gnt,
    output logic       R,
    output logic       G,
    output logic       B,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    // Down-counter reload: SHOW spans HOLD cycles including the entry cycle.
    localparam logic [7:0] c_HOLD_LOAD = 8'(HOLD - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_a;
    logic [1:0] r_b;

    logic       w_sel;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;
    logic [2:0] w_sel_rgb;
    logic [2:0] w_lat_rgb;

    // {a<=b, a!=b, a>=b} for an unsigned 2-bit pair.
    function automatic logic [2:0] f_cmp(input logic [1:0] a, input logic [1:0] b);
        return {(a <= b), (a != b), (a >= b)};
    endfunction

    // Round-robin pick: a lone request wins outright; on contention the
    // requester that was not served last wins.
    always_comb begin
        w_sel = ~owner;
        case (req)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            default: w_sel = ~owner;
        endcase
        w_sel_a   = w_sel ? a1 : a0;
        w_sel_b   = w_sel ? b1 : b0;
        w_sel_rgb = f_cmp(w_sel_a, w_sel_b);
        w_lat_rgb = f_cmp(r_a, r_b);
    end

    // Single FSM with registered outputs; async reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_a     <= 2'd0;
            r_b     <= 2'd0;
            gnt     <= 2'b00;
            R       <= 1'b0;
            G       <= 1'b0;
            B       <= 1'b0;
            busy    <= 1'b0;
            owner   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    gnt       <= 2'b00;
                    {R, G, B} <= 3'b000;
                    busy      <= 1'b0;
                    if (req != 2'b00) begin
                        // Result is computed from the live inputs so it is
                        // valid in the same cycle as the grant pulse.
                        r_state   <= S_SHOW;
                        r_a       <= w_sel_a;
                        r_b       <= w_sel_b;
                        r_cnt     <= c_HOLD_LOAD;
                        owner     <= w_sel;
                        gnt       <= w_sel ? 2'b10 : 2'b01;
                        {R, G, B} <= w_sel_rgb;
                        busy      <= 1'b1;
                    end
                end
                S_SHOW: begin
                    gnt  <= 2'b00;
                    busy <= 1'b1;
                    if (r_cnt == 8'd0) begin
                        r_state   <= S_BLANK;
                        {R, G, B} <= 3'b000;
                    end else begin
                        // Refresh from the latched pair only, so input
                        // changes during SHOW cannot disturb the display.
                        r_cnt     <= r_cnt - 8'd1;
                        {R, G, B} <= w_lat_rgb;
                    end
                end
                S_BLANK: begin
                    r_state   <= S_IDLE;
                    gnt       <= 2'b00;
                    {R, G, B} <= 3'b000;
                    busy      <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= 8'd0;
                    gnt       <= 2'b00;
                    {R, G, B} <= 3'b000;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgb_cmp_arbiter.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : tb_rgb_cmp_arbiter
//  Brief    : Self-checking bench for rgb_cmp_arbiter; two instances
//             (HOLD=4 and HOLD=1) checked against a timeline model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rgb_cmp_arbiter;

    localparam int H0 = 4;
    localparam int H1 = 1;

    logic            clk;
    logic            rst_n;
    logic [1:0][1:0] req_s;
    logic [1:0][1:0] a0_s;
    logic [1:0][1:0] b0_s;
    logic [1:0][1:0] a1_s;
    logic [1:0][1:0] b1_s;
    logic [1:0][1:0] gnt_s;
    logic [1:0]      r_s;
    logic [1:0]      g_s;
    logic [1:0]      b_s;
    logic [1:0]      busy_s;
    logic [1:0]      own_s;

    int n_tests = 0;
    int n_fail  = 0;

    rgb_cmp_arbiter #(.HOLD(H0)) u_h4 (
        .clk  (clk),     .rst_n(rst_n),   .req  (req_s[0]),
        .a0   (a0_s[0]), .b0   (b0_s[0]), .a1   (a1_s[0]), .b1(b1_s[0]),
        .gnt  (gnt_s[0]),.R    (r_s[0]),  .G    (g_s[0]),  .B (b_s[0]),
        .busy (busy_s[0]), .owner(own_s[0])
    );

    rgb_cmp_arbiter #(.HOLD(H1)) u_h1 (
        .clk  (clk),     .rst_n(rst_n),   .req  (req_s[1]),
        .a0   (a0_s[1]), .b0   (b0_s[1]), .a1   (a1_s[1]), .b1(b1_s[1]),
        .gnt  (gnt_s[1]),.R    (r_s[1]),  .G    (g_s[1]),  .B (b_s[1]),
        .busy (busy_s[1]), .owner(own_s[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- timeline model ----------------
    // m_n counts clock edges since reset; m_g is the edge index of the last
    // grant. Everything else follows from the distance between the two.
    int         m_n;
    int         m_g   [2];
    int         m_a   [2];
    int         m_b   [2];
    logic       m_own [2];

    function automatic int hold_of(input int k);
        return (k == 0) ? H0 : H1;
    endfunction

    function automatic logic [2:0] rgb_of(input int a, input int b);
        return {(a <= b), (a != b), (a >= b)};
    endfunction

    function automatic logic [6:0] expect_of(input int k);
        int         p;
        logic [1:0] eg;
        logic [2:0] ec;
        logic       eb;
        p  = m_n - m_g[k];
        eg = 2'b00;
        ec = 3'b000;
        eb = 1'b0;
        if (p >= 0 && p < hold_of(k)) ec = rgb_of(m_a[k], m_b[k]);
        if (p == 0) eg = m_own[k] ? 2'b10 : 2'b01;
        if (p >= 0 && p <= hold_of(k)) eb = 1'b1;
        return {eg, ec, eb, m_own[k]};
    endfunction

    function automatic logic [6:0] obs(input int k);
        return {gnt_s[k], r_s[k], g_s[k], b_s[k], busy_s[k], own_s[k]};
    endfunction

    initial begin
        m_n = 0;
        for (int k = 0; k < 2; k++) begin
            m_g[k] = -1000; m_a[k] = 0; m_b[k] = 0; m_own[k] = 1'b1;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_n = 0;
                for (int k = 0; k < 2; k++) begin
                    m_g[k] = -1000; m_a[k] = 0; m_b[k] = 0; m_own[k] = 1'b1;
                end
            end else begin
                m_n = m_n + 1;
                for (int k = 0; k < 2; k++) begin
                    // Idle once SHOW (HOLD) + BLANK (1) have elapsed.
                    if ((m_n - m_g[k] >= hold_of(k) + 2) && (req_s[k] != 2'b00)) begin
                        int w;
                        if (req_s[k] == 2'b01)      w = 0;
                        else if (req_s[k] == 2'b10) w = 1;
                        else                        w = m_own[k] ? 0 : 1;
                        m_g[k]   = m_n;
                        m_own[k] = (w == 1);
                        m_a[k]   = (w == 1) ? int'(a1_s[k]) : int'(a0_s[k]);
                        m_b[k]   = (w == 1) ? int'(b1_s[k]) : int'(b0_s[k]);
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: gnt,R,G,B,busy,owner got %b required %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("cycle_u0", obs(0), expect_of(0));
            chk("cycle_u1", obs(1), expect_of(1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [1:0] rq, input logic [1:0] x0,
                         input logic [1:0] y0, input logic [1:0] x1, input logic [1:0] y1);
        req_s[k] = rq;
        a0_s[k]  = x0;
        b0_s[k]  = y0;
        a1_s[k]  = x1;
        b1_s[k]  = y1;
    endtask

    initial begin
        int nz;
        int gc;
        rst_n = 1'b0;
        drive(0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
        drive(1, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
        step(2);
        chk("reset_u0", obs(0), 7'b00_000_0_1);
        chk("reset_u1", obs(1), 7'b00_000_0_1);
        rst_n = 1'b1;
        step(1);
        chk("idle_after_reset", obs(0), 7'b00_000_0_1);

        // Single request, HOLD=4: 1<=2, 1!=2, !(1>=2)
        drive(0, 2'b01, 2'd1, 2'd2, 2'd0, 2'd0);
        step(1);
        chk("single_grant", obs(0), 7'b01_110_1_0);
        drive(0, 2'b00, 2'd1, 2'd2, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("single_show", obs(0), 7'b00_110_1_0);
        end
        step(1);
        chk("single_blank", obs(0), 7'b00_000_1_0);
        step(1);
        chk("single_idle", obs(0), 7'b00_000_0_0);

        // Contention after reset
        #2 rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        drive(0, 2'b11, 2'd3, 2'd0, 2'd2, 2'd2);
        step(1);
        chk("rr_first", obs(0), 7'b01_011_1_0);
        step(5);
        chk("rr_gap_idle", obs(0), 7'b00_000_0_0);
        step(1);
        chk("rr_second", obs(0), 7'b10_101_1_1);
        drive(0, 2'b00, 2'd3, 2'd0, 2'd2, 2'd2);
        step(6);
        chk("rr_done", obs(0), 7'b00_000_0_1);

        // Operand change mid-SHOW
        drive(0, 2'b01, 2'd0, 2'd2, 2'd0, 2'd0);
        step(1);
        chk("hold_grant", obs(0), 7'b01_110_1_0);
        drive(0, 2'b00, 2'd0, 2'd2, 2'd0, 2'd0);
        step(1);
        drive(0, 2'b00, 2'd3, 2'd2, 2'd0, 2'd0);
        step(1);
        chk("hold_stable_a", obs(0), 7'b00_110_1_0);
        step(1);
        chk("hold_stable_b", obs(0), 7'b00_110_1_0);
        step(1);
        chk("hold_blank", obs(0), 7'b00_000_1_0);
        step(1);

        // Exhaustive 2-bit comparison on requester 0
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                logic [2:0] e;
                e = {(a <= b), (a != b), (a >= b)};
                drive(0, 2'b01, 2'(a), 2'(b), 2'd0, 2'd0);
                step(1);
                chk($sformatf("cmp_a%0d_b%0d", a, b), obs(0), {2'b01, e, 1'b1, 1'b0});
                drive(0, 2'b00, 2'(a), 2'(b), 2'd0, 2'd0);
                step(5);
            end
        end

        // HOLD=1 boundary on the second instance, req=10 held
        drive(1, 2'b10, 2'd0, 2'd0, 2'd0, 2'd1);
        nz = 0;
        gc = 0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            if (obs(1)[4:2] != 3'b000) nz++;
            if (gnt_s[1] == 2'b10) gc++;
            case (i % 3)
                0:       chk("h1_grant", obs(1), 7'b10_110_1_1);
                1:       chk("h1_blank", obs(1), 7'b00_000_1_1);
                default: chk("h1_idle",  obs(1), 7'b00_000_0_1);
            endcase
        end
        chk_int("h1_rgb_cycles", nz, 3);
        chk_int("h1_grants", gc, 3);
        drive(1, 2'b00, 2'd0, 2'd0, 2'd0, 2'd1);
        step(3);

        // Async reset mid-SHOW
        drive(0, 2'b01, 2'd1, 2'd2, 2'd0, 2'd0);
        step(2);
        chk("pre_reset_show", obs(0), 7'b00_110_1_0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_u0", obs(0), 7'b00_000_0_1);
        chk("async_reset_u1", obs(1), 7'b00_000_0_1);
        drive(0, 2'b11, 2'd3, 2'd0, 2'd2, 2'd2);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1);
        chk("post_reset_grant", obs(0), 7'b01_011_1_0);
        drive(0, 2'b00, 2'd3, 2'd0, 2'd2, 2'd2);
        step(7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
